uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width, parity and stop-bit count. Reports per-frame parity and framing errors and flags overrun. Delivers words over a valid/ready handshake with a one-entry holding register, and sits between the board RX pin and the sample-loading logic.

Parameters:
TICKS_PER_BIT, 64, i_clk cycles per bit; legal range 4..4096. Counter width is $clog2(TICKS_PER_BIT).
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked per frame: 1 or 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_rx_serial  in  1  asynchronous serial line, idle high
i_rx_ready  in  1  consumer ready to accept o_rx_data
o_rx_valid  out  1  o_rx_data/status hold an unconsumed word
o_rx_data  out  DATA_BITS  received word, bit 0 = first data bit
o_parity_err  out  1  parity mismatch on held word (0 when PARITY=0)
o_frame_err  out  1  a stop bit sampled low on held word
o_overrun  out  1  one-cycle pulse: frame completed while holding register full and not being emptied

Behaviour:
- Reset (i_rst=1, async):
  - synchroniser flops = 1; state = IDLE; counters = 0.
  - o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0, o_overrun=0.
  - Reset mid-frame abandons the frame. No output is produced for it.
- Input path: 2-flop synchroniser; all decisions use the second flop (rx_s).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: count=0, bit_idx=0. rx_s==0 -> START.
  - START: count increments each cycle. At count==(TICKS_PER_BIT-1)/2, sample. Sample 0 -> count=0, go to DATA. Sample 1 (glitch) -> IDLE, no output.
  - DATA: sample when count==TICKS_PER_BIT-1, then count=0. The sample goes to shift[bit_idx]. After bit DATA_BITS-1: go to PARITY if PARITY!=0, else STOP.
  - PARITY: one bit period. Parity error when XOR(data bits, parity bit) is 0 for odd mode or 1 for even mode.
  - STOP: STOP_BITS periods. Any stop sample 0 sets frame_err. After the last stop sample:
    - commit (below);
    - then go to IDLE if the last stop sample was 1, else WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This covers break / line held low, which yields exactly one frame_err word and no spurious restart.
- Commit occurs on the cycle after the last stop sample (the commit cycle):
  - Holding register empty, or i_rx_ready=1 in the commit cycle: load data and both error bits; o_rx_valid=1.
  - Otherwise: new frame discarded, held word unchanged, o_overrun=1 for exactly that cycle.
- Handshake:
  - Transfer occurs when o_rx_valid & i_rx_ready at a rising edge. o_rx_valid then clears unless a commit happens in the same cycle; if so, o_rx_valid stays 1 with the new word.
  - o_rx_data and the error bits are stable while o_rx_valid=1 and not transferred.
- Latency: o_rx_valid rises one cycle after the final stop-bit sample, i.e. (1+DATA_BITS+P+STOP_BITS-0.5)*TICKS_PER_BIT + 3 cycles after the line falls (±1 cycle of synchroniser phase). P=1 if PARITY!=0, else 0.
- A new start bit may be accepted in the cycle immediately after IDLE is re-entered. Back-to-back frames with no idle gap must work.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined:
  - Every sample point (start check, data, parity, stop) takes three consecutive rx_s values at count = mid-1, mid, mid+1 and uses their 2-of-3 majority. Decision is made at mid+1.
  - The start check uses mid=(TICKS_PER_BIT-1)/2. Data/parity/stop bits use mid=TICKS_PER_BIT-1 relative to the previous decision point, so bit-period spacing is unchanged.
  - All latencies above grow by 1 cycle.
  - Requires TICKS_PER_BIT>=8.
- Undefined: single sample as described in Behaviour.

Test Plan:
- TICKS_PER_BIT=16, 8N1, send 0xA5 with i_rx_ready=1 -> o_rx_valid=1 for exactly one cycle, o_rx_data=0xA5, both error bits 0; latency per formula.
- PARITY=2 (even), send 0x3C with parity bit 1 -> o_rx_data=0x3C, o_parity_err=1; repeat with parity bit 0 -> o_parity_err=0.
- STOP_BITS=2, send 0x55 with second stop bit 0, line then held low 40 cycles -> o_frame_err=1, one word only, no new frame until line returns high.
- Line low for 3 cycles then high (TICKS_PER_BIT=16) -> no o_rx_valid, FSM back in IDLE; with UART_RX_MAJORITY_EN, one-cycle low glitch inside a data bit does not flip the bit.
- i_rx_ready=0, send 0x11 then 0x22 back-to-back -> o_rx_data stays 0x11, o_overrun pulses 1 cycle at second commit; then ready=1 -> transfer, o_rx_valid=0.
- Assert i_rst mid-DATA of 0x7E, release, send 0x81 -> only 0x81 delivered, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
// with a one-entry valid/ready holding register. Define UART_RX_MAJORITY_EN for 2-of-3 sampling (TICKS_PER_BIT >= 8).
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | line idle, waiting for rx_s to fall
// S_START     | timing to mid start bit, glitch rejection
// S_DATA      | sampling DATA_BITS data bits, LSB first
// S_PARITY    | sampling the parity bit (only when PARITY != 0)
// S_STOP      | sampling STOP_BITS stop bits, commit on the last one
// S_WAIT_HIGH | last stop bit was low (break); wait for the line to return high

module uart_rx_ext #(
    parameter int TICKS_PER_BIT = 64,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_serial,
    input  logic                 i_rx_ready,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(TICKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_TC = (TICKS_PER_BIT - 1) / 2 + 1;
`else
    localparam int START_TC = (TICKS_PER_BIT - 1) / 2;
`endif
    localparam logic [CW-1:0] START_END = CW'(START_TC);
    localparam logic [CW-1:0] BIT_END   = CW'(TICKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 bit_smp;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 start_done;
    logic                 bit_done;
    logic                 last_data;
    logic                 last_stop;
    logic                 commit;
    logic                 par_calc;
    logic                 par_err_w;
    logic                 ferr_w;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx_serial};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist holds rx_s from the two previous cycles; the decision cycle supplies the third vote
    logic [1:0] hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_smp = rx_s;
`endif

    assign start_done = (cnt == START_END);
    assign bit_done   = (cnt == BIT_END);
    assign last_data  = (bit_idx == LAST_BIT);
    assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign commit     = (state == S_STOP) && bit_done && last_stop;

    assign par_calc  = ^{shift, par_bit};
    assign par_err_w = (PARITY == 1) ? ~par_calc :
                       (PARITY == 2) ?  par_calc : 1'b0;
    assign ferr_w    = ferr_acc | ~bit_smp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (start_done) state_nxt = bit_smp ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_done && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_done) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_done && last_stop) state_nxt = bit_smp ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    cnt <= start_done ? '0 : cnt + CW'(1);
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        shift   <= {bit_smp, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        par_bit <= bit_smp;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        cnt      <= '0;
                        stop_idx <= ~stop_idx;
                        if (!bit_smp) ferr_acc <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    ferr_acc <= 1'b0;
                end
            endcase
        end
    end

    // A commit coinciding with a transfer refills the register in the same edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
            if (commit) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_valid   <= 1'b1;
                    o_rx_data    <= shift;
                    o_parity_err <= par_err_w;
                    o_frame_err  <= ferr_w;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

    held_word_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_rx_valid && !i_rx_ready) |=> ($stable(o_rx_data) && $stable(o_parity_err) && $stable(o_frame_err)));

    overrun_single_cycle: assert property (@(posedge i_clk) disable iff (i_rst)
        o_overrun |=> !o_overrun);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: three instances (8N1, 8E1, 8N2) at 16 ticks per bit.
// Expected words are queued when a frame is driven and popped on each valid/ready transfer.

module tb_uart_rx_ext;

    localparam int T = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ser   [3];
    logic       rdy   [3];
    logic       valid [3];
    logic [7:0] data  [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       ovr   [3];

    exp_t sb [3][$];
    int   ovr_cnt [3];
    int   words   [3];
    int   n_chk;
    int   n_err;
    int   cyc;

    uart_rx_ext #(.TICKS_PER_BIT(T), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(ser[0]), .i_rx_ready(rdy[0]),
        .o_rx_valid(valid[0]), .o_rx_data(data[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_overrun(ovr[0]));

    uart_rx_ext #(.TICKS_PER_BIT(T), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(ser[1]), .i_rx_ready(rdy[1]),
        .o_rx_valid(valid[1]), .o_rx_data(data[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_overrun(ovr[1]));

    uart_rx_ext #(.TICKS_PER_BIT(T), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(ser[2]), .i_rx_ready(rdy[2]),
        .o_rx_valid(valid[2]), .o_rx_data(data[2]), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_overrun(ovr[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // monitor: every transfer pops one expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    if (ovr[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
                    if (valid[i] && rdy[i]) begin
                        words[i] = words[i] + 1;
                        if (sb[i].size() == 0) begin
                            chk($sformatf("unexpected_word_%0d", i), {24'h0, data[i]}, 32'hFFFF_FFFF);
                        end else begin
                            e = sb[i].pop_front();
                            chk($sformatf("data_%0d", i), {24'h0, data[i]}, {24'h0, e.d});
                            chk($sformatf("perr_%0d", i), {31'h0, perr[i]}, {31'h0, e.pe});
                            chk($sformatf("ferr_%0d", i), {31'h0, ferr[i]}, {31'h0, e.fe});
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input bit has_par, input logic pbit,
                        input int nstop, input logic [1:0] stops);
        ser[i] = 1'b0;
        repeat (T) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            ser[i] = d[b];
            repeat (T) @(negedge clk);
        end
        if (has_par) begin
            ser[i] = pbit;
            repeat (T) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            ser[i] = stops[s];
            repeat (T) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int i, input int budget, output int seen);
        seen = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (valid[i]) begin
                seen = cyc;
                break;
            end
        end
    endtask

    function automatic int lat_exp(input int p, input int s);
        return (9 + p + s) * T - T / 2 + 3 + MAJ;
    endfunction

    // drives a frame on instance i while timing the first o_rx_valid from the falling edge
    task automatic send_timed(input int i, input string tag, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops, input int lat);
        int c0;
        int seen;
        c0 = cyc;
        fork
            send(i, d, has_par, pbit, nstop, stops);
            begin
                wait_valid(i, 400, seen);
                chk({tag, "_latency"}, seen - c0, lat);
                @(negedge clk);
                chk({tag, "_valid_one_cycle"}, {31'h0, valid[i]}, 32'h0);
            end
        join
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ser[i] = 1'b1;
            rdy[i] = 1'b0;
            ovr_cnt[i] = 0;
            words[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid_%0d", i), {31'h0, valid[i]}, 32'h0);
            chk($sformatf("rst_data_%0d", i), {24'h0, data[i]}, 32'h0);
            chk($sformatf("rst_flags_%0d", i), {29'h0, perr[i], ferr[i], ovr[i]}, 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5
        sb[0].push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_timed(0, "a5", 8'hA5, 1'b0, 1'b0, 1, 2'b01, lat_exp(0, 1));
        repeat (4) @(negedge clk);

        // even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right
        sb[1].push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0});
        send_timed(1, "par_bad", 8'h3C, 1'b1, 1'b1, 1, 2'b01, lat_exp(1, 1));
        repeat (4) @(negedge clk);
        sb[1].push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
        send(1, 8'h3C, 1'b1, 1'b0, 1, 2'b01);
        repeat (4) @(negedge clk);
        chk("par_words_left", sb[1].size(), 0);

        // two stop bits, second one low, then line held low (break)
        sb[2].push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1});
        send(2, 8'h55, 1'b0, 1'b0, 2, 2'b01);
        repeat (40) @(negedge clk);
        chk("break_words", words[2], 1);
        chk("break_valid_low", {31'h0, valid[2]}, 32'h0);
        ser[2] = 1'b1;
        repeat (3 * T) @(negedge clk);
        chk("break_no_restart", words[2], 1);
        sb[2].push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        send_timed(2, "after_break", 8'hC3, 1'b0, 1'b0, 2, 2'b11, lat_exp(0, 2));
        repeat (4) @(negedge clk);
        chk("break_words_left", sb[2].size(), 0);

        // short low glitch on the line must not start a frame
        ser[0] = 1'b0;
        repeat (3) @(negedge clk);
        ser[0] = 1'b1;
        repeat (3 * T) @(negedge clk);
        chk("glitch_no_word", words[0], 1);
        sb[0].push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
        send_timed(0, "after_glitch", 8'h5A, 1'b0, 1'b0, 1, 2'b01, lat_exp(0, 1));
        repeat (4) @(negedge clk);

`ifdef UART_RX_MAJORITY_EN
        // one-cycle low pulse at the centre of data bit 3 is outvoted
        sb[0].push_back('{d: 8'hFF, pe: 1'b0, fe: 1'b0});
        ser[0] = 1'b0;
        repeat (T) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            ser[0] = 1'b1;
            if (b == 3) begin
                repeat (7) @(negedge clk);
                ser[0] = 1'b0;
                @(negedge clk);
                ser[0] = 1'b1;
                repeat (8) @(negedge clk);
            end else begin
                repeat (T) @(negedge clk);
            end
        end
        ser[0] = 1'b1;
        repeat (T + 4) @(negedge clk);
        chk("maj_words_left", sb[0].size(), 0);
`endif

        // overrun: consumer stalled, two frames back-to-back
        rdy[0] = 1'b0;
        repeat (2) @(negedge clk);
        sb[0].push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
        send(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
        send(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
        repeat (4) @(negedge clk);
        chk("ovr_valid_held", {31'h0, valid[0]}, 32'h1);
        chk("ovr_data_held", {24'h0, data[0]}, 32'h11);
        chk("ovr_pulses", ovr_cnt[0], 1);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_valid_cleared", {31'h0, valid[0]}, 32'h0);
        chk("ovr_words_left", sb[0].size(), 0);

        // reset in the middle of the data bits of 0x7E
        ser[0] = 1'b0;
        repeat (T) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            ser[0] = (b != 0);
            repeat (T) @(negedge clk);
        end
        rst = 1'b1;
        ser[0] = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'h0, valid[0]}, 32'h0);
        chk("midrst_data", {24'h0, data[0]}, 32'h0);
        chk("midrst_flags", {29'h0, perr[0], ferr[0], ovr[0]}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sb[0].push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
        send_timed(0, "after_rst", 8'h81, 1'b0, 1'b0, 1, 2'b01, lat_exp(0, 1));
        repeat (2 * T) @(negedge clk);

        chk("end_sb0", sb[0].size(), 0);
        chk("end_sb1", sb[1].size(), 0);
        chk("end_sb2", sb[2].size(), 0);
        chk("end_ovr1", ovr_cnt[1], 0);
        chk("end_ovr2", ovr_cnt[2], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
